// File: rtl/sme_pkg.sv
`default_nettype none
// =============================================================================
// Module  : sme_pkg
// Brief   : Shared character codes, buffer depths, driver states and result type
//           for the string-match-engine host driver.
// Rev     : 1.0  initial release
// =============================================================================
package sme_pkg;

   localparam logic [7:0] CH_START = 8'd94;
   localparam logic [7:0] CH_END   = 8'd36;
   localparam logic [7:0] CH_ANY   = 8'd46;
   localparam logic [7:0] CH_SPACE = 8'd32;

   localparam int STR_DEPTH = 32;
   localparam int PAT_DEPTH = 10;
   localparam int TO_CYCLES = 1023;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SEND_STR = 3'd1,
      ST_SEND_PAT = 3'd2,
      ST_WAIT     = 3'd3,
      ST_REPORT   = 3'd4
   } drv_state_e;

   typedef struct packed {
      logic       match;
      logic [4:0] index;
      logic       timeout;
   } sme_result_t;

endpackage
`default_nettype wire

// File: rtl/sme_drv_buf.sv
`default_nettype none
// =============================================================================
// Module  : sme_drv_buf
// Brief   : Two-bank (string / pattern) character register file, one write port
//           and one registered read port that returns 0 when not reading.
// Rev     : 1.0  initial release
// =============================================================================
module sme_drv_buf
   import sme_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       we_i,
   input  logic       wsel_i,
   input  logic [4:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic       re_i,
   input  logic       rsel_i,
   input  logic [4:0] raddr_i,
   output logic [7:0] rdata_o
);

   logic [7:0] str_mem_q [STR_DEPTH];
   logic [7:0] pat_mem_q [PAT_DEPTH];
   logic [7:0] rdata_q;
   logic       str_we;
   logic       pat_we;

   assign str_we = we_i && !wsel_i && ({1'b0, waddr_i} < 6'(STR_DEPTH));
   assign pat_we = we_i &&  wsel_i && ({1'b0, waddr_i} < 6'(PAT_DEPTH));

   always_ff @(posedge clk) begin
      if (str_we) str_mem_q[waddr_i] <= wdata_i;
      if (pat_we) pat_mem_q[waddr_i[3:0]] <= wdata_i;
   end

   // Idle reads return 0 so the read register doubles as the chardata driver.
   always_ff @(posedge clk) begin
      if (reset || !re_i) rdata_q <= '0;
      else if (rsel_i)    rdata_q <= pat_mem_q[raddr_i[3:0]];
      else                rdata_q <= str_mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/sme_host_driver.sv
`default_nettype none
// =============================================================================
// Module  : sme_host_driver
// Brief   : Streams a buffered string/pattern job to the match engine and
//           captures its result. Optional WAIT watchdog: SME_DRV_TIMEOUT_EN.
// Rev     : 1.0  initial release
// =============================================================================
module sme_host_driver
   import sme_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_we,
   input  logic       cfg_sel,
   input  logic [4:0] cfg_addr,
   input  logic [7:0] cfg_data,
   input  logic [5:0] str_len,
   input  logic [3:0] pat_len,
   input  logic       reuse_str,
   input  logic       start,
   output logic       busy,
   output logic       done,
   output logic       res_match,
   output logic [4:0] res_index,
   output logic       res_timeout,
   output logic [7:0] chardata,
   output logic       isstring,
   output logic       ispattern,
   input  logic       match,
   input  logic [4:0] match_index,
   input  logic       valid
);

   drv_state_e  state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [5:0]  str_len_q, str_len_d;
   logic [3:0]  pat_len_q, pat_len_d;
   logic        str_sent_q, str_sent_d;
   logic        isstring_q, isstring_d;
   logic        ispattern_q, ispattern_d;
   sme_result_t res_q, res_d;
`ifdef SME_DRV_TIMEOUT_EN
   logic [9:0]  to_cnt_q, to_cnt_d;
`endif

   logic        rd_en;
   logic        rd_sel;
   logic [4:0]  rd_addr;
   logic [5:0]  str_len_eff;
   logic [3:0]  pat_len_eff;
   logic        send_str;

   // A zero length is a reuse request; if no string is held yet the full buffer goes out.
   always_comb begin
      if (str_len == 6'd0 || str_len > 6'(STR_DEPTH)) str_len_eff = 6'(STR_DEPTH);
      else                                             str_len_eff = str_len;
      if (pat_len > 4'(PAT_DEPTH)) pat_len_eff = 4'(PAT_DEPTH);
      else                         pat_len_eff = pat_len;
      send_str = !((reuse_str || str_len == 6'd0) && str_sent_q);
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      str_len_d   = str_len_q;
      pat_len_d   = pat_len_q;
      str_sent_d  = str_sent_q;
      res_d       = res_q;
      isstring_d  = 1'b0;
      ispattern_d = 1'b0;
      rd_en       = 1'b0;
      rd_sel      = 1'b0;
      rd_addr     = '0;
`ifdef SME_DRV_TIMEOUT_EN
      to_cnt_d    = to_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start && pat_len != 4'd0) begin
               str_len_d = str_len_eff;
               pat_len_d = pat_len_eff;
               idx_d     = '0;
               rd_en     = 1'b1;
               if (send_str) begin
                  state_d    = ST_SEND_STR;
                  isstring_d = 1'b1;
               end else begin
                  state_d     = ST_SEND_PAT;
                  rd_sel      = 1'b1;
                  ispattern_d = 1'b1;
               end
            end
         end
         ST_SEND_STR: begin
            rd_en = 1'b1;
            if ({1'b0, idx_q} == str_len_q - 6'd1) begin
               state_d     = ST_SEND_PAT;
               idx_d       = '0;
               rd_sel      = 1'b1;
               ispattern_d = 1'b1;
               str_sent_d  = 1'b1;
            end else begin
               idx_d      = idx_q + 5'd1;
               rd_addr    = idx_q + 5'd1;
               isstring_d = 1'b1;
            end
         end
         ST_SEND_PAT: begin
            if (idx_q == {1'b0, pat_len_q} - 5'd1) begin
               state_d = ST_WAIT;
`ifdef SME_DRV_TIMEOUT_EN
               to_cnt_d = '0;
`endif
            end else begin
               idx_d       = idx_q + 5'd1;
               rd_en       = 1'b1;
               rd_sel      = 1'b1;
               rd_addr     = idx_q + 5'd1;
               ispattern_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (valid) begin
               res_d.match   = match;
               res_d.index   = match_index;
               res_d.timeout = 1'b0;
               state_d       = ST_REPORT;
            end
`ifdef SME_DRV_TIMEOUT_EN
            else if (to_cnt_q == 10'(TO_CYCLES - 1)) begin
               res_d.match   = 1'b0;
               res_d.index   = '0;
               res_d.timeout = 1'b1;
               state_d       = ST_REPORT;
            end else begin
               to_cnt_d = to_cnt_q + 10'd1;
            end
`endif
         end
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         str_len_q   <= '0;
         pat_len_q   <= '0;
         str_sent_q  <= 1'b0;
         isstring_q  <= 1'b0;
         ispattern_q <= 1'b0;
         res_q       <= '0;
`ifdef SME_DRV_TIMEOUT_EN
         to_cnt_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         str_len_q   <= str_len_d;
         pat_len_q   <= pat_len_d;
         str_sent_q  <= str_sent_d;
         isstring_q  <= isstring_d;
         ispattern_q <= ispattern_d;
         res_q       <= res_d;
`ifdef SME_DRV_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
`endif
      end
   end

   sme_drv_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .we_i    (cfg_we && state_q == ST_IDLE),
      .wsel_i  (cfg_sel),
      .waddr_i (cfg_addr),
      .wdata_i (cfg_data),
      .re_i    (rd_en),
      .rsel_i  (rd_sel),
      .raddr_i (rd_addr),
      .rdata_o (chardata)
   );

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_REPORT);
   assign isstring    = isstring_q;
   assign ispattern   = ispattern_q;
   assign res_match   = res_q.match;
   assign res_index   = res_q.index;
`ifdef SME_DRV_TIMEOUT_EN
   assign res_timeout = res_q.timeout;
`else
   assign res_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sme_host_driver.sv
`default_nettype none
// =============================================================================
// Module  : tb_sme_host_driver
// Brief   : Directed jobs against a per-cycle expected-trace model of the driver.
// Rev     : 1.0  initial release
// =============================================================================
module tb_sme_host_driver;

   localparam int TB_TO = 1023;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we, cfg_sel;
   logic [4:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [5:0] str_len;
   logic [3:0] pat_len;
   logic       reuse_str, start;
   logic       busy, done, res_match, res_timeout;
   logic [4:0] res_index;
   logic [7:0] chardata;
   logic       isstring, ispattern;
   logic       match, valid;
   logic [4:0] match_index;

   sme_host_driver dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .str_len(str_len), .pat_len(pat_len),
      .reuse_str(reuse_str), .start(start), .busy(busy), .done(done),
      .res_match(res_match), .res_index(res_index), .res_timeout(res_timeout),
      .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
      .match(match), .match_index(match_index), .valid(valid)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy, done, s, p;
      logic [7:0] ch;
      logic       rm;
      logic [4:0] ri;
      logic       rt;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] m_str [32];
   logic [7:0] m_pat [10];
   logic       m_rm, m_rt, m_sent;
   logic [4:0] m_ri;
   bit         chk_en;
   int         n_pass, n_total, n_s, n_p, n_d;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Every cycle: pop the next expected entry, or expect a quiet idle interface.
   always @(negedge clk) begin
      exp_t e;
      if (chk_en) begin
         if (exp_q.size() > 0) e = exp_q.pop_front();
         else e = '{busy:1'b0, done:1'b0, s:1'b0, p:1'b0, ch:8'd0, rm:m_rm, ri:m_ri, rt:m_rt};
         chk("busy",        32'(busy),        32'(e.busy));
         chk("done",        32'(done),        32'(e.done));
         chk("isstring",    32'(isstring),    32'(e.s));
         chk("ispattern",   32'(ispattern),   32'(e.p));
         chk("chardata",    32'(chardata),    32'(e.ch));
         chk("res_match",   32'(res_match),   32'(e.rm));
         chk("res_index",   32'(res_index),   32'(e.ri));
         chk("res_timeout", 32'(res_timeout), 32'(e.rt));
         chk("exclusive",   32'(isstring & ispattern), 32'd0);
         if (isstring)  n_s++;
         if (ispattern) n_p++;
         if (done)      n_d++;
      end
   end

   task automatic wr(input bit sel, input int addr, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 5'(addr); cfg_data = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (!sel && addr < 32) m_str[addr] = d;
      else if (sel && addr < 10) m_pat[addr] = d;
   endtask

   task automatic load(input bit sel, input string s);
      for (int i = 0; i < s.len(); i++) wr(sel, i, s[i]);
   endtask

   task automatic launch(input bit reuse, input int slen, input int plen);
      @(negedge clk);
      str_len = 6'(slen); pat_len = 4'(plen); reuse_str = reuse; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_job(input bit reuse, input int slen, input int plen, input int d,
                          input bit m, input logic [4:0] mi, input bit no_valid,
                          input bit disturb);
      int   L, P, wcnt, cur;
      bit   snd;
      exp_t e;
      snd  = !((reuse || slen == 0) && m_sent);
      L    = !snd ? 0 : ((slen == 0 || slen > 32) ? 32 : slen);
      P    = (plen > 10) ? 10 : plen;
      wcnt = no_valid ? TB_TO : d + 1;
      n_s = 0; n_p = 0; n_d = 0;
      launch(reuse, slen, plen);
      e = '{busy:1'b1, done:1'b0, s:1'b1, p:1'b0, ch:8'd0, rm:m_rm, ri:m_ri, rt:m_rt};
      for (int i = 0; i < L; i++) begin e.ch = m_str[i]; exp_q.push_back(e); end
      e.s = 1'b0; e.p = 1'b1;
      for (int j = 0; j < P; j++) begin e.ch = m_pat[j]; exp_q.push_back(e); end
      e.p = 1'b0; e.ch = 8'd0;
      for (int w = 0; w < wcnt; w++) exp_q.push_back(e);
      if (no_valid) begin m_rm = 1'b0; m_ri = 5'd0; m_rt = 1'b1; end
      else          begin m_rm = m;    m_ri = mi;   m_rt = 1'b0; end
      e.done = 1'b1; e.rm = m_rm; e.ri = m_ri; e.rt = m_rt;
      exp_q.push_back(e);
      m_sent = m_sent | snd;
      cur = 0;
      if (disturb) begin
         repeat (L) @(posedge clk);
         #1;
         start = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 5'd0; cfg_data = "Z";
         valid = 1'b1; match = 1'b1; match_index = 5'd9;
         @(posedge clk); #1;
         start = 1'b0; cfg_we = 1'b0; valid = 1'b0; match = 1'b0; match_index = 5'd0;
         cur = L + 1;
      end
      if (!no_valid) begin
         repeat (L + P + d - cur) @(posedge clk);
         #1;
         valid = 1'b1; match = m; match_index = mi;
         @(posedge clk); #1;
         valid = 1'b0; match = 1'b0; match_index = 5'd0;
      end
      for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(posedge clk);
      #1;
      chk("job_drain", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
      str_len = '0; pat_len = '0; reuse_str = 1'b0; start = 1'b0;
      match = 1'b0; match_index = '0; valid = 1'b0;
      m_rm = 1'b0; m_ri = '0; m_rt = 1'b0; m_sent = 1'b0;
      chk_en = 1'b0; n_pass = 0; n_total = 0; n_s = 0; n_p = 0; n_d = 0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_char", 32'(chardata), 32'd0);
      chk("rst_res",  32'({res_match, res_index, res_timeout}), 32'd0);

      for (int i = 0; i < 32; i++) wr(1'b0, i, 8'h41 + 8'(i));
      for (int i = 0; i < 10; i++) wr(1'b1, i, 8'h30 + 8'(i));

      // reuse requested right after reset: no string held, so it is sent anyway
      run_job(1'b1, 5, 2, 0, 1'b0, 5'd3, 1'b0, 1'b0);
      chk("j1_nstr", 32'(n_s), 32'd5);
      chk("j1_npat", 32'(n_p), 32'd2);

      load(1'b0, "abc ab");
      load(1'b1, "ab");
      run_job(1'b0, 6, 2, 2, 1'b1, 5'd0, 1'b0, 1'b0);
      chk("j2_nstr",  32'(n_s), 32'd6);
      chk("j2_npat",  32'(n_p), 32'd2);
      chk("j2_match", 32'(res_match), 32'd1);
      chk("j2_index", 32'(res_index), 32'd0);

      load(1'b1, "^ab$");
      run_job(1'b1, 6, 4, 1, 1'b1, 5'd4, 1'b0, 1'b0);
      chk("j3_nstr",  32'(n_s), 32'd0);
      chk("j3_npat",  32'(n_p), 32'd4);
      chk("j3_index", 32'(res_index), 32'd4);

      // start, cfg_we and a stray valid during SEND_PAT must all be ignored
      run_job(1'b0, 6, 4, 3, 1'b0, 5'd7, 1'b0, 1'b1);
      chk("j4_ndone", 32'(n_d), 32'd1);
      chk("j4_match", 32'(res_match), 32'd0);
      run_job(1'b1, 0, 4, 0, 1'b1, 5'd2, 1'b0, 1'b0);
      chk("j5_nstr", 32'(n_s), 32'd0);
      chk("j5_pat0", 32'(m_pat[0]), 32'(8'd94));

      launch(1'b0, 6, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("pat0_busy", 32'(busy), 32'd0);

      run_job(1'b0, 40, 15, 0, 1'b1, 5'd31, 1'b0, 1'b0);
      chk("j6_nstr",  32'(n_s), 32'd32);
      chk("j6_npat",  32'(n_p), 32'd10);
      chk("j6_index", 32'(res_index), 32'd31);

      // reset during the third string cycle
      launch(1'b0, 6, 2);
      e = '{busy:1'b1, done:1'b0, s:1'b1, p:1'b0, ch:8'd0, rm:m_rm, ri:m_ri, rt:m_rt};
      for (int i = 0; i < 3; i++) begin e.ch = m_str[i]; exp_q.push_back(e); end
      exp_q.push_back('0);
      m_rm = 1'b0; m_ri = 5'd0; m_rt = 1'b0; m_sent = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_str",  32'(isstring), 32'd0);
      run_job(1'b1, 6, 2, 1, 1'b1, 5'd1, 1'b0, 1'b0);
      chk("j7_nstr", 32'(n_s), 32'd6);

`ifdef SME_DRV_TIMEOUT_EN
      run_job(1'b1, 6, 2, 0, 1'b0, 5'd0, 1'b1, 1'b0);
      chk("to_flag",  32'(res_timeout), 32'd1);
      chk("to_match", 32'(res_match), 32'd0);
      run_job(1'b1, 6, 2, 0, 1'b1, 5'd5, 1'b0, 1'b0);
      chk("to_clear", 32'(res_timeout), 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
